// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty sequencer: default sizes, sequencer
// state encoding and the target clamp helper.
package pwm_pkg;

    localparam int DEF_PERIOD_SLOTS = 10;
    localparam int DEF_DUTY_W       = 4;
    localparam int DEF_DIV_W        = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } seq_state_e;

    // Requests above the period length saturate at fully-on.
    function automatic int clamp_duty(input int req, input int limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/pwm_slot_counter.sv
// Free-running PWM slot counter; flags the last slot (the edge leaving it is
// the period boundary) and the first slot of every period.
module pwm_slot_counter
    import pwm_pkg::*;
#(
    parameter int PERIOD_SLOTS = DEF_PERIOD_SLOTS,
    parameter int SLOT_W       = DEF_DUTY_W
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [SLOT_W-1:0] slot,
    output logic              boundary,
    output logic              period_start
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PERIOD_SLOTS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (boundary) begin
            slot <= '0;
        end else begin
            slot <= slot + 1'b1;
        end
    end

    assign boundary     = (slot == LAST_SLOT);
    assign period_start = (slot == '0);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Soft-start/soft-stop duty sequencer: accepts a target duty and walks the
// applied duty toward it one step per (step_div+1) PWM periods.
// Optional build macro PWM_SEQ_RETARGET_EN keeps tgt_ready high while ramping.
module pwm_duty_sequencer
    import pwm_pkg::*;
#(
    parameter int PERIOD_SLOTS = DEF_PERIOD_SLOTS,
    parameter int DUTY_W       = DEF_DUTY_W,
    parameter int DIV_W        = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tgt_valid,
    output logic              tgt_ready,
    input  logic [DUTY_W-1:0] tgt_duty,
    input  logic [DIV_W-1:0]  step_div,
    output logic [DUTY_W-1:0] duty,
    output logic [DUTY_W-1:0] slot,
    output logic              period_start,
    output logic              busy,
    output logic              done
);

    seq_state_e        state, state_nx;
    logic [DUTY_W-1:0] target, target_nx;
    logic [DUTY_W-1:0] duty_nx;
    logic [DUTY_W-1:0] req_duty;
    logic [DIV_W-1:0]  div, div_nx;
    logic [DIV_W-1:0]  pcnt, pcnt_nx;
    logic              done_nx;
    logic              boundary;
    logic              accept;

    pwm_slot_counter #(
        .PERIOD_SLOTS (PERIOD_SLOTS),
        .SLOT_W       (DUTY_W)
    ) u_slot_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .slot         (slot),
        .boundary     (boundary),
        .period_start (period_start)
    );

`ifdef PWM_SEQ_RETARGET_EN
    assign tgt_ready = 1'b1;
`else
    assign tgt_ready = (state == IDLE);
`endif

    assign accept   = tgt_valid && tgt_ready;
    assign req_duty = DUTY_W'(clamp_duty(int'(tgt_duty), PERIOD_SLOTS));
    assign busy     = (state == RAMP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            duty   <= '0;
            target <= '0;
            div    <= '0;
            pcnt   <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            duty   <= duty_nx;
            target <= target_nx;
            div    <= div_nx;
            pcnt   <= pcnt_nx;
            done   <= done_nx;
        end
    end

    // Duty only moves on the edge into slot 0, so the comparator never sees a
    // change in the middle of a period.
    always_comb begin
        state_nx  = state;
        duty_nx   = duty;
        target_nx = target;
        div_nx    = div;
        pcnt_nx   = pcnt;
        done_nx   = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept) begin
                    target_nx = req_duty;
                    div_nx    = step_div;
                    pcnt_nx   = step_div;
                    if (req_duty != duty) begin
                        state_nx = RAMP;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            RAMP: begin
                // A mid-ramp accept is only possible with retargeting built in;
                // the period divider keeps counting but no step is taken.
                if (accept) begin
                    target_nx = req_duty;
                    div_nx    = step_div;
                    if (boundary && pcnt != '0) begin
                        pcnt_nx = pcnt - 1'b1;
                    end
                    if (req_duty == duty) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                end else if (boundary) begin
                    if (pcnt != '0) begin
                        pcnt_nx = pcnt - 1'b1;
                    end else begin
                        duty_nx = (target > duty) ? duty + 1'b1 : duty - 1'b1;
                        pcnt_nx = div;
                        if (duty_nx == target) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Self-checking bench for pwm_duty_sequencer: directed ramps with pinned
// latencies, then randomized requests against a schedule-based reference model.
module tb_pwm_duty_sequencer;

    logic       clk;
    logic       rst_n;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [3:0] tgt_duty;
    logic [7:0] step_div;
    logic [3:0] duty;
    logic [3:0] slot;
    logic       period_start;
    logic       busy;
    logic       done;

    int tests_run;
    int tests_failed;

    pwm_duty_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tgt_valid    (tgt_valid),
        .tgt_ready    (tgt_ready),
        .tgt_duty     (tgt_duty),
        .step_div     (step_div),
        .duty         (duty),
        .slot         (slot),
        .period_start (period_start),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a ramp is a schedule. Counting period boundaries since
    // the accept, the applied duty is start +/- (boundaries / (div+1)),
    // saturated at the target.
    int cyc;
    int m_duty, m_start, m_target, m_k, m_bnd0;
    int m_nb, m_steps, m_span, m_req;
    bit m_ramp, m_done;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc    = 0;
            m_duty = 0;
            m_ramp = 0;
            m_done = 0;
        end else begin
            m_done = 0;
            m_nb   = (cyc + 1) / 10;
            if (m_ramp) begin
                if (cyc % 10 == 9) begin
                    m_steps = (m_nb - m_bnd0) / (m_k + 1);
                    m_span  = (m_target > m_start) ? m_target - m_start : m_start - m_target;
                    if (m_steps > m_span) m_steps = m_span;
                    m_duty = (m_target > m_start) ? m_start + m_steps : m_start - m_steps;
                    if (m_duty == m_target) begin
                        m_ramp = 0;
                        m_done = 1;
                    end
                end
            end else if (tgt_valid) begin
                m_req = (int'(tgt_duty) > 10) ? 10 : int'(tgt_duty);
                if (m_req == m_duty) begin
                    m_done = 1;
                end else begin
                    m_ramp   = 1;
                    m_start  = m_duty;
                    m_target = m_req;
                    m_k      = int'(step_div);
                    m_bnd0   = m_nb;
                end
            end
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("slot",         int'(slot),         cyc % 10);
            checkOutput("period_start", int'(period_start), (cyc % 10 == 0) ? 1 : 0);
            checkOutput("duty",         int'(duty),         m_duty);
            checkOutput("busy",         int'(busy),         int'(m_ramp));
            checkOutput("tgt_ready",    int'(tgt_ready),    m_ramp ? 0 : 1);
            checkOutput("done",         int'(done),         int'(m_done));
        end
    end

    // Presents one request, aligned so it is accepted on the edge leaving slot 5.
    task automatic applyStimulus(input int tgt, input int div);
        int guard;
        guard = 0;
        while (slot != 4'd5 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tgt_valid = 1'b1;
        tgt_duty  = 4'(tgt);
        step_div  = 8'(div);
        @(negedge clk);
        tgt_valid = 1'b0;
    endtask

    task automatic waitDone(input int max_cycles, output int c);
        c = 0;
        while (done !== 1'b1 && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        if (done !== 1'b1) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic resetCheck();
        checkOutput("rst_duty",         int'(duty),         0);
        checkOutput("rst_slot",         int'(slot),         0);
        checkOutput("rst_period_start", int'(period_start), 1);
        checkOutput("rst_tgt_ready",    int'(tgt_ready),    1);
        checkOutput("rst_busy",         int'(busy),         0);
        checkOutput("rst_done",         int'(done),         0);
    endtask

    initial begin
        int c;
        int starts;
        int guard;
        tests_run    = 0;
        tests_failed = 0;
        tgt_valid    = 1'b0;
        tgt_duty     = '0;
        step_div     = '0;
        rst_n        = 1'b0;
        #12;
        resetCheck();
        rst_n = 1'b1;

        starts = 0;
        repeat (30) begin
            @(negedge clk);
            if (period_start) starts++;
        end
        checkOutput("period_start_count", starts, 3);

        // Fast ramp 0 -> 5, one step per period.
        applyStimulus(5, 0);
        waitDone(200, c);
        checkOutput("fast_latency", c, 44);
        checkOutput("fast_duty", int'(duty), 5);
        checkOutput("fast_busy", int'(busy), 0);
        @(negedge clk);
        checkOutput("fast_done_pulse", int'(done), 0);

        applyStimulus(8, 0);
        waitDone(200, c);
        checkOutput("up8_latency", c, 24);
        checkOutput("up8_duty", int'(duty), 8);

        // Ramp down 8 -> 6.
        applyStimulus(6, 0);
        waitDone(200, c);
        checkOutput("down_latency", c, 14);
        checkOutput("down_duty", int'(duty), 6);

        applyStimulus(0, 0);
        waitDone(200, c);
        checkOutput("down0_duty", int'(duty), 0);

        // Clamp: 15 saturates at 10.
        applyStimulus(15, 0);
        waitDone(200, c);
        checkOutput("clamp_latency", c, 94);
        checkOutput("clamp_duty", int'(duty), 10);

        // No-op request at the current duty.
        applyStimulus(12, 0);
        waitDone(20, c);
        checkOutput("noop_latency", c, 0);
        checkOutput("noop_busy", int'(busy), 0);

        // Requests during a ramp are held off.
        applyStimulus(0, 0);
        tgt_valid = 1'b1;
        tgt_duty  = 4'd3;
        repeat (50) begin
            @(negedge clk);
            checkOutput("ramp_ready_low", int'(tgt_ready), 0);
        end
        tgt_valid = 1'b0;
        waitDone(200, c);
        checkOutput("ignored_duty", int'(duty), 0);

        // Asynchronous reset in the middle of a ramp.
        applyStimulus(8, 0);
        guard = 0;
        while (duty != 4'd4 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("reach_duty4", int'(duty), 4);
        #3 rst_n = 1'b0;
        #1 resetCheck();
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Slow ramp 0 -> 2, one step every three periods.
        applyStimulus(2, 2);
        waitDone(200, c);
        checkOutput("slow_latency", c, 54);
        checkOutput("slow_duty", int'(duty), 2);

        // Randomized traffic, checked every cycle by the model.
        repeat (3000) begin
            @(negedge clk);
            tgt_valid = ($urandom_range(0, 5) == 0);
            tgt_duty  = 4'($urandom_range(0, 15));
            step_div  = 8'($urandom_range(0, 2));
        end
        tgt_valid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
